// File: rtl/tile_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// tile_ram_arbiter_if
//
// Bundles the three buses around the tile RAM arbiter:
//   host_*  : Avalon-MM style host port (read/write, waitrequest,
//             readdatavalid)
//   scan_*  : read-only request/grant port of the LED scan-out engine
//   mem_*   : single-port tile RAM with a registered read (data valid the
//             cycle after the address is issued)
//
// Modports
//   slave  : the arbiter side (consumes host/scan requests, drives the RAM)
//   master : the environment side (requesters and the RAM itself)
// ---------------------------------------------------------------------------
interface tile_ram_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) ();
    localparam int BE_W = DATA_W / 8;

    // host port
    logic [ADDR_W-1:0] host_address;
    logic              host_read;
    logic              host_write;
    logic [BE_W-1:0]   host_byteenable;
    logic [DATA_W-1:0] host_writedata;
    logic              host_waitrequest;
    logic [DATA_W-1:0] host_readdata;
    logic              host_readdatavalid;

    // scan port
    logic              scan_req;
    logic [ADDR_W-1:0] scan_address;
    logic              scan_gnt;
    logic [DATA_W-1:0] scan_rdata;
    logic              scan_rvalid;

    // RAM port
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  host_address, host_read, host_write, host_byteenable, host_writedata,
        output host_waitrequest, host_readdata, host_readdatavalid,
        input  scan_req, scan_address,
        output scan_gnt, scan_rdata, scan_rvalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport master (
        output host_address, host_read, host_write, host_byteenable, host_writedata,
        input  host_waitrequest, host_readdata, host_readdatavalid,
        output scan_req, scan_address,
        input  scan_gnt, scan_rdata, scan_rvalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken,
        output mem_readdata
    );

endinterface

// File: rtl/tile_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tile_ram_arbiter
//
// Shares the single-port tile RAM between the host and the LED scan-out
// engine. Arbitration is combinational every cycle: scan wins contention so
// the display refresh never stalls, but after MAX_SCAN_STREAK consecutive
// scan wins against a waiting host, the host gets the next slot.
//
// Out-of-range accesses (address >= DEPTH) are accepted like any other, but
// the RAM is not selected: writes are dropped and reads return zero on the
// normal schedule.
//
// Read timing: request granted in cycle N, RAM data arrives in N+1 and is
// registered into the owner's return port, valid is high in N+2 for one
// cycle. A {valid, owner, oor} tag captured at the end of N steers the data.
//
// Ports
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : host / scan / RAM signals (tile_ram_arbiter_if.slave)
// ---------------------------------------------------------------------------
module tile_ram_arbiter #(
    parameter int ADDR_W          = 14,
    parameter int DATA_W          = 16,
    parameter int DEPTH           = 13000,
    parameter int MAX_SCAN_STREAK = 4
) (
    input logic               clk,
    input logic               reset_n,
    tile_ram_arbiter_if.slave bus
);

    localparam int BE_W     = DATA_W / 8;
    localparam int STREAK_W = 4;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_SCAN_STREAK);
    // one extra bit so DEPTH == 2**ADDR_W would still compare correctly
    localparam logic [ADDR_W:0]     DEPTH_EXT  = (ADDR_W + 1)'(DEPTH);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [STREAK_W-1:0] streak_reg,  streak_next;
    logic                tag_valid_reg, tag_valid_next;
    logic                tag_owner_reg, tag_owner_next;   // 1 = scan, 0 = host
    logic                tag_oor_reg,   tag_oor_next;
    logic                mem_clken_reg;
    logic [DATA_W-1:0]   host_rdata_reg;
    logic                host_rvalid_reg;
    logic [DATA_W-1:0]   scan_rdata_reg;
    logic                scan_rvalid_reg;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic host_pending;
    logic host_is_read;
    logic host_oor;
    logic scan_oor;
    logic streak_full;
    logic scan_grant;
    logic host_grant;

    assign host_pending = bus.host_read | bus.host_write;
    // read and write together is a write: no read response is produced
    assign host_is_read = bus.host_read & ~bus.host_write;

    assign host_oor = ({1'b0, bus.host_address} >= DEPTH_EXT);
    assign scan_oor = ({1'b0, bus.scan_address} >= DEPTH_EXT);

    assign streak_full = (streak_reg == STREAK_MAX);

    // Scan loses only when the host is waiting and scan has used its streak.
    assign scan_grant = bus.scan_req & ~(host_pending & streak_full);
    assign host_grant = host_pending & ~scan_grant;

    assign bus.scan_gnt         = scan_grant;
    assign bus.host_waitrequest = host_pending & ~host_grant;

    // -----------------------------------------------------------------------
    // Streak counter: counts scan wins against a waiting host
    // -----------------------------------------------------------------------
    always_comb begin
        streak_next = streak_reg;
        if (!host_pending || host_grant) begin
            streak_next = '0;
        end else if (scan_grant && !streak_full) begin
            streak_next = streak_reg + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // RAM drive, combinational from the granted side
    // -----------------------------------------------------------------------
    always_comb begin
        bus.mem_address    = '0;
        bus.mem_chipselect = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_writedata  = '0;
        if (scan_grant) begin
            bus.mem_address    = bus.scan_address;
            bus.mem_chipselect = ~scan_oor;
        end else if (host_grant) begin
            bus.mem_address    = bus.host_address;
            bus.mem_chipselect = ~host_oor;
            bus.mem_write      = bus.host_write & ~host_oor;
            bus.mem_writedata  = bus.host_writedata;
        end
    end

    // Per-lane byte enables: scan reads whole words, host uses its own lanes.
    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_be_lane
            assign bus.mem_byteenable[gi] = scan_grant |
                                            (host_grant & bus.host_byteenable[gi]);
        end
    endgenerate

    assign bus.mem_clken = mem_clken_reg;

    // -----------------------------------------------------------------------
    // Read tag for the request issued this cycle
    // -----------------------------------------------------------------------
    always_comb begin
        tag_valid_next = scan_grant | (host_grant & host_is_read);
        tag_owner_next = scan_grant;
        tag_oor_next   = scan_grant ? scan_oor : host_oor;
    end

    // Data returning from the RAM this cycle; out-of-range reads return zero.
    logic [DATA_W-1:0] ret_data;
    assign ret_data = tag_oor_reg ? '0 : bus.mem_readdata;

    // -----------------------------------------------------------------------
    // State registers and return-data pipeline
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak_reg      <= '0;
            tag_valid_reg   <= 1'b0;
            tag_owner_reg   <= 1'b0;
            tag_oor_reg     <= 1'b0;
            mem_clken_reg   <= 1'b0;
            host_rdata_reg  <= '0;
            host_rvalid_reg <= 1'b0;
            scan_rdata_reg  <= '0;
            scan_rvalid_reg <= 1'b0;
        end else begin
            // RAM clock is enabled from the first clock after reset release
            mem_clken_reg   <= 1'b1;
            streak_reg      <= streak_next;
            tag_valid_reg   <= tag_valid_next;
            tag_owner_reg   <= tag_owner_next;
            tag_oor_reg     <= tag_oor_next;

            host_rvalid_reg <= tag_valid_reg & ~tag_owner_reg;
            scan_rvalid_reg <= tag_valid_reg &  tag_owner_reg;

            // data registers only move on a return; otherwise they hold
            if (tag_valid_reg && !tag_owner_reg) begin
                host_rdata_reg <= ret_data;
            end
            if (tag_valid_reg && tag_owner_reg) begin
                scan_rdata_reg <= ret_data;
            end
        end
    end

    assign bus.host_readdata      = host_rdata_reg;
    assign bus.host_readdatavalid = host_rvalid_reg;
    assign bus.scan_rdata         = scan_rdata_reg;
    assign bus.scan_rvalid        = scan_rvalid_reg;

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tile_ram_arbiter
//
// Table of per-cycle request vectors with expected grant / RAM-drive values,
// plus a scoreboard of expected read returns (data and due cycle) for the
// host and scan ports. A behavioural registered-read RAM sits on the mem
// side; a separate shadow array holds the contents the bench expects.
// Hand-written sequences cover reset values, mem_clken after release and
// reset in the middle of an outstanding read.
// ---------------------------------------------------------------------------
module tb_tile_ram_arbiter;

    localparam int AW    = 14;
    localparam int DW    = 16;
    localparam int DEPTH = 13000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    tile_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    tile_ram_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .DEPTH          (DEPTH),
        .MAX_SCAN_STREAK(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 37 + 11) ^ 16'hA5C3;
    endfunction

    // -----------------------------------------------------------------------
    // Behavioural tile RAM (registered read, byte-enable writes)
    // -----------------------------------------------------------------------
    logic [15:0] ram [0:DEPTH-1];
    logic        ram_loaded = 1'b0;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
            ram_loaded       <= 1'b1;
            bus.mem_readdata <= '0;
        end else if (bus.mem_clken && bus.mem_chipselect) begin
            if (bus.mem_write) begin
                if (bus.mem_byteenable[0]) ram[bus.mem_address][7:0]  <= bus.mem_writedata[7:0];
                if (bus.mem_byteenable[1]) ram[bus.mem_address][15:8] <= bus.mem_writedata[15:8];
            end else begin
                bus.mem_readdata <= ram[bus.mem_address];
            end
        end
    end

    logic [15:0] shadow [0:DEPTH-1];

    function automatic logic [15:0] exp_rd(input logic [13:0] a);
        if (int'(a) >= DEPTH) return 16'h0000;
        return shadow[a];
    endfunction

    // -----------------------------------------------------------------------
    // Scoreboard of expected returns
    // -----------------------------------------------------------------------
    typedef struct {
        int          due;
        logic [15:0] data;
    } sb_t;

    sb_t         host_q[$];
    sb_t         scan_q[$];
    logic        mon_en    = 1'b0;
    logic [15:0] last_host = '0;
    logic [15:0] last_scan = '0;
    sb_t         he;
    sb_t         se;

    always @(negedge clk) begin
        if (mon_en) begin
            if (host_q.size() > 0 && host_q[0].due == cyc) begin
                he = host_q.pop_front();
                chk("host_rvalid", 32'(bus.host_readdatavalid), 32'd1);
                chk("host_rdata", 32'(bus.host_readdata), 32'(he.data));
                last_host = he.data;
                $display("host return data=0x%04h cycle=%0d", bus.host_readdata, cyc);
            end else begin
                chk("host_rvalid_idle", 32'(bus.host_readdatavalid), 32'd0);
                chk("host_rdata_hold", 32'(bus.host_readdata), 32'(last_host));
            end
            if (scan_q.size() > 0 && scan_q[0].due == cyc) begin
                se = scan_q.pop_front();
                chk("scan_rvalid", 32'(bus.scan_rvalid), 32'd1);
                chk("scan_rdata", 32'(bus.scan_rdata), 32'(se.data));
                last_scan = se.data;
                $display("scan return data=0x%04h cycle=%0d", bus.scan_rdata, cyc);
            end else begin
                chk("scan_rvalid_idle", 32'(bus.scan_rvalid), 32'd0);
                chk("scan_rdata_hold", 32'(bus.scan_rdata), 32'(last_scan));
            end
        end
    end

    // -----------------------------------------------------------------------
    // Vector table
    // -----------------------------------------------------------------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  be;
        logic [13:0] haddr;
        logic [15:0] wdata;
        logic        sreq;
        logic [13:0] saddr;
        logic        e_gnt;
        logic        e_wait;
        logic        e_cs;
        logic        e_we;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rd, input logic wr, input logic [1:0] be,
        input logic [13:0] ha, input logic [15:0] wd,
        input logic sq, input logic [13:0] sa,
        input logic g, input logic w, input logic cs, input logic we);
        vec_t v;
        v.rd = rd; v.wr = wr; v.be = be; v.haddr = ha; v.wdata = wd;
        v.sreq = sq; v.saddr = sa;
        v.e_gnt = g; v.e_wait = w; v.e_cs = cs; v.e_we = we;
        return v;
    endfunction

    task automatic drive_idle();
        bus.host_read       = 1'b0;
        bus.host_write      = 1'b0;
        bus.host_byteenable = 2'b00;
        bus.host_address    = '0;
        bus.host_writedata  = '0;
        bus.scan_req        = 1'b0;
        bus.scan_address    = '0;
    endtask

    task automatic apply(input vec_t v);
        logic        hgnt;
        logic [13:0] e_addr;
        logic [1:0]  e_be;
        @(posedge clk);
        #1;
        bus.host_read       = v.rd;
        bus.host_write      = v.wr;
        bus.host_byteenable = v.be;
        bus.host_address    = v.haddr;
        bus.host_writedata  = v.wdata;
        bus.scan_req        = v.sreq;
        bus.scan_address    = v.saddr;
        @(negedge clk);
        hgnt   = (v.rd | v.wr) & ~v.e_wait;
        e_addr = v.e_gnt ? v.saddr : (hgnt ? v.haddr : 14'd0);
        e_be   = v.e_gnt ? 2'b11 : v.be;
        $display("vec rd=%0b wr=%0b ha=0x%04h sreq=%0b sa=0x%04h -> gnt=%0b wait=%0b cs=%0b we=%0b",
                 v.rd, v.wr, v.haddr, v.sreq, v.saddr,
                 bus.scan_gnt, bus.host_waitrequest, bus.mem_chipselect, bus.mem_write);
        chk("scan_gnt", 32'(bus.scan_gnt), 32'(v.e_gnt));
        chk("host_waitrequest", 32'(bus.host_waitrequest), 32'(v.e_wait));
        chk("mem_chipselect", 32'(bus.mem_chipselect), 32'(v.e_cs));
        chk("mem_write", 32'(bus.mem_write), 32'(v.e_we));
        chk("mem_address", 32'(bus.mem_address), 32'(e_addr));
        if (v.e_gnt || hgnt) chk("mem_byteenable", 32'(bus.mem_byteenable), 32'(e_be));
        if (v.e_gnt) scan_q.push_back('{due: cyc + 2, data: exp_rd(v.saddr)});
        if (hgnt && v.rd && !v.wr) host_q.push_back('{due: cyc + 2, data: exp_rd(v.haddr)});
        if (hgnt && v.wr && int'(v.haddr) < DEPTH) begin
            if (v.be[0]) shadow[v.haddr][7:0]  = v.wdata[7:0];
            if (v.be[1]) shadow[v.haddr][15:8] = v.wdata[15:8];
        end
    endtask

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        for (int i = 0; i < DEPTH; i++) shadow[i] = pat(i);
        drive_idle();

        // host write/read, byte lanes, both-asserted, out of range
        vecs.push_back(mk(0,1,2'b11,14'h0010,16'h1234, 0,14'h0, 0,0,1,1));
        vecs.push_back(mk(1,0,2'b11,14'h0010,16'h0000, 0,14'h0, 0,0,1,0));
        vecs.push_back(mk(0,1,2'b11,14'h0020,16'hABCD, 0,14'h0, 0,0,1,1));
        vecs.push_back(mk(0,1,2'b01,14'h0020,16'h0011, 0,14'h0, 0,0,1,1));
        vecs.push_back(mk(1,0,2'b11,14'h0020,16'h0000, 0,14'h0, 0,0,1,0));
        vecs.push_back(mk(0,1,2'b11,14'd13000,16'h5555,0,14'h0, 0,0,0,0));
        vecs.push_back(mk(1,0,2'b11,14'd13000,16'h0000,0,14'h0, 0,0,0,0));
        vecs.push_back(mk(1,0,2'b11,14'd12999,16'h0000,0,14'h0, 0,0,1,0));
        vecs.push_back(mk(1,1,2'b11,14'h0030,16'h7777, 0,14'h0, 0,0,1,1));
        vecs.push_back(mk(1,0,2'b11,14'h0030,16'h0000, 0,14'h0, 0,0,1,0));
        vecs.push_back(mk(0,0,2'b00,14'h0000,16'h0000, 0,14'h0, 0,0,0,0));
        // back-to-back scan reads, host idle
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(0,0,2'b00,14'h0,16'h0, 1,14'(k), 1,0,1,0));
        // scan out of range
        vecs.push_back(mk(0,0,2'b00,14'h0,16'h0, 1,14'd13001, 1,0,0,0));
        // contention: S,S,S,S,H repeating
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(1,0,2'b11,14'h0010,16'h0, 1,14'(k + 8),
                              (k % 5) != 4, (k % 5) != 4, 1, 0));
        // host not pending clears the streak; next contention is won by scan
        vecs.push_back(mk(0,0,2'b00,14'h0,16'h0, 1,14'h0002, 1,0,1,0));
        vecs.push_back(mk(0,0,2'b00,14'h0,16'h0, 1,14'h0003, 1,0,1,0));
        vecs.push_back(mk(1,0,2'b11,14'h0020,16'h0, 1,14'h0004, 1,1,1,0));
        vecs.push_back(mk(1,0,2'b11,14'h0020,16'h0, 0,14'h0000, 0,0,1,0));
        vecs.push_back(mk(0,0,2'b00,14'h0000,16'h0000, 0,14'h0, 0,0,0,0));

        // ---- reset values ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_host_rvalid", 32'(bus.host_readdatavalid), 32'd0);
        chk("rst_host_rdata", 32'(bus.host_readdata), 32'd0);
        chk("rst_scan_rvalid", 32'(bus.scan_rvalid), 32'd0);
        chk("rst_scan_rdata", 32'(bus.scan_rdata), 32'd0);
        chk("rst_mem_clken", 32'(bus.mem_clken), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("clken_before_clock", 32'(bus.mem_clken), 32'd0);
        @(posedge clk);
        #1;
        chk("clken_after_clock", 32'(bus.mem_clken), 32'd1);
        mon_en = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // drain outstanding returns
        @(posedge clk);
        #1;
        drive_idle();
        repeat (4) @(negedge clk);
        chk("host_q_drained", 32'(host_q.size()), 32'd0);
        chk("scan_q_drained", 32'(scan_q.size()), 32'd0);

        // ---- reset while a host read is in flight ----
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        bus.host_read    = 1'b1;
        bus.host_address = 14'h0020;
        @(negedge clk);
        chk("mid_read_granted", 32'(bus.host_waitrequest), 32'd0);
        @(posedge clk);
        #1;
        drive_idle();
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_host_rvalid", 32'(bus.host_readdatavalid), 32'd0);
        chk("midrst_host_rdata", 32'(bus.host_readdata), 32'd0);
        chk("midrst_scan_rvalid", 32'(bus.scan_rvalid), 32'd0);
        chk("midrst_scan_rdata", 32'(bus.scan_rdata), 32'd0);
        chk("midrst_mem_clken", 32'(bus.mem_clken), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("midrst_clken_before", 32'(bus.mem_clken), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_clken_after", 32'(bus.mem_clken), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_host_rvalid", 32'(bus.host_readdatavalid), 32'd0);
            chk("post_rst_scan_rvalid", 32'(bus.scan_rvalid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
